tlp_demux: RTL and testbench

- Downstream stage of the transaction-layer arbiter (referee).
- Takes one 12-bit TLP word per cycle popped from the VC FIFOs and routes it by its destination field into one of four output FIFOs (push_0..push_3).
- Absorbs output-FIFO almost_full backpressure with an in-order hold buffer.
- Signals stall upstream so the arbiter stops popping.
- Keeps per-destination push counters for the checker/bench.

---
 rtl/tlp_demux_if.sv | 40 ++++
 rtl/tlp_demux.sv | 122 ++++++++++++
 tb/tb_tlp_demux.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/tlp_demux_if.sv
// Bundles the word stream, output-FIFO push/backpressure and counter-read
// signals of the TLP demultiplexer.
interface tlp_demux_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned CNT_W  = 8
);
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              almost_full_0;
  logic              almost_full_1;
  logic              almost_full_2;
  logic              almost_full_3;
  logic              push_0;
  logic              push_1;
  logic              push_2;
  logic              push_3;
  logic [DATA_W-1:0] data_out;
  logic              stall;
  logic              overflow;
  logic [1:0]        cnt_idx;
  logic              cnt_rd;
  logic [CNT_W-1:0]  cnt_out;
  logic              cnt_valid;

  modport slave (
    input  valid_in, data_in,
    input  almost_full_0, almost_full_1, almost_full_2, almost_full_3,
    input  cnt_idx, cnt_rd,
    output push_0, push_1, push_2, push_3, data_out, stall, overflow,
    output cnt_out, cnt_valid
  );

  modport master (
    output valid_in, data_in,
    output almost_full_0, almost_full_1, almost_full_2, almost_full_3,
    output cnt_idx, cnt_rd,
    input  push_0, push_1, push_2, push_3, data_out, stall, overflow,
    input  cnt_out, cnt_valid
  );
endinterface

// File: rtl/tlp_demux.sv
// Routes arbiter words to four output FIFOs by destination field, holding
// blocked words in an in-order buffer and keeping per-destination push counts.
module tlp_demux #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned DEST_LSB   = 8,
  parameter int unsigned HOLD_DEPTH = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic         clk,
  input  logic         reset,
  tlp_demux_if.slave   bus
);
  localparam int unsigned AW = $clog2(HOLD_DEPTH);
  localparam int unsigned OW = AW + 1;

  typedef enum logic [1:0] {S_EMPTY, S_HOLDING, S_FULL} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_mem [HOLD_DEPTH];
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [OW-1:0]     r_occ;
  logic [3:0]        r_push;
  logic [DATA_W-1:0] r_data;
  logic              r_stall;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_cnt [4];
  logic [CNT_W-1:0]  r_cnt_out;
  logic              r_cnt_valid;

  logic              w_buf_ne;
  logic              w_full;
  logic              w_stall_nxt;
  logic [3:0]        w_af_vec;
  logic [DATA_W-1:0] w_cand;
  logic [1:0]        w_dest;
  logic              w_issue;
  logic              w_head_issue;
  logic              w_wr;
  logic              w_drop;
  logic [OW-1:0]     w_occ_nxt;

  // Issue decision: buffer head has priority; data_in bypasses only when empty
  always_comb begin
    w_af_vec     = {bus.almost_full_3, bus.almost_full_2,
                    bus.almost_full_1, bus.almost_full_0};
    w_cand       = w_buf_ne ? r_mem[r_rd_ptr] : bus.data_in;
    w_dest       = w_cand[DEST_LSB +: 2];
    w_issue      = (w_buf_ne | bus.valid_in) & ~w_af_vec[w_dest];
    w_head_issue = w_issue & w_buf_ne;
    w_wr         = 1'b0;
    w_drop       = 1'b0;
    if (bus.valid_in && !(w_issue && !w_buf_ne)) begin
      if (w_full && !w_head_issue) w_drop = 1'b1;
      else                         w_wr   = 1'b1;
    end
    w_occ_nxt = r_occ + OW'(w_wr) - OW'(w_head_issue);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_occ_nxt == OW'(0))               w_state_nxt = S_EMPTY;
    else if (w_occ_nxt == OW'(HOLD_DEPTH)) w_state_nxt = S_FULL;
    else                                   w_state_nxt = S_HOLDING;
  end

  always_comb begin
    w_buf_ne    = (r_state != S_EMPTY);
    w_full      = (r_state == S_FULL);
    w_stall_nxt = (w_state_nxt != S_EMPTY);
  end

  // Storage array carries no reset; pointers define what is valid
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_occ       <= '0;
      r_push      <= '0;
      r_data      <= '0;
      r_stall     <= 1'b0;
      r_overflow  <= 1'b0;
      r_cnt_out   <= '0;
      r_cnt_valid <= 1'b0;
      for (int n = 0; n < 4; n++) r_cnt[n] <= '0;
    end else begin
      r_occ   <= w_occ_nxt;
      r_stall <= w_stall_nxt;
      r_push  <= w_issue ? (4'b0001 << w_dest) : 4'b0000;
      if (w_issue)      r_data     <= w_cand;
      if (w_wr)         r_wr_ptr   <= r_wr_ptr + AW'(1);
      if (w_head_issue) r_rd_ptr   <= r_rd_ptr + AW'(1);
      if (w_drop)       r_overflow <= 1'b1;
      // Read samples pre-increment value when a push lands the same cycle
      r_cnt_valid <= bus.cnt_rd;
      if (bus.cnt_rd) r_cnt_out <= r_cnt[bus.cnt_idx];
      for (int n = 0; n < 4; n++) begin
        if (w_issue && (w_dest == 2'(n))) r_cnt[n] <= r_cnt[n] + CNT_W'(1);
      end
    end
  end

  assign bus.push_0    = r_push[0];
  assign bus.push_1    = r_push[1];
  assign bus.push_2    = r_push[2];
  assign bus.push_3    = r_push[3];
  assign bus.data_out  = r_data;
  assign bus.stall     = r_stall;
  assign bus.overflow  = r_overflow;
  assign bus.cnt_out   = r_cnt_out;
  assign bus.cnt_valid = r_cnt_valid;
endmodule

// File: tb/tb_tlp_demux.sv
// Scoreboard bench for tlp_demux: expected pushes queued at stimulus time,
// popped and compared by a monitor on every observed push.
module tb_tlp_demux;
  typedef struct packed {
    logic [1:0]  dest;
    logic [11:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  tlp_demux_if #(.DATA_W(12), .CNT_W(8)) bus ();

  tlp_demux u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [3:0] pushes();
    return {bus.push_3, bus.push_2, bus.push_1, bus.push_0};
  endfunction

  task automatic send(input logic [11:0] w, input logic [1:0] d, input bit exp_push);
    bus.valid_in = 1'b1;
    bus.data_in  = w;
    if (exp_push) exp_q.push_back({d, w});
    step();
    bus.valid_in = 1'b0;
  endtask

  task automatic read_cnt(input logic [1:0] idx, input logic [7:0] exp);
    bus.cnt_rd  = 1'b1;
    bus.cnt_idx = idx;
    step();
    bus.cnt_rd = 1'b0;
    chk("cnt_valid", 32'(bus.cnt_valid), 32'd1);
    chk("cnt_out", 32'(bus.cnt_out), 32'(exp));
  endtask

  // Monitor: every observed push must match the head of the expected queue
  always @(negedge clk) begin
    if (reset && pushes() != 4'b0000) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_push", 32'(pushes()), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("push_onehot", 32'(pushes()), 32'(4'b0001 << e.dest));
        chk("data_out", 32'(bus.data_out), 32'(e.data));
      end
    end
  end

  initial begin
    reset             = 1'b0;
    bus.valid_in      = 1'b0;
    bus.data_in       = '0;
    bus.almost_full_0 = 1'b0;
    bus.almost_full_1 = 1'b0;
    bus.almost_full_2 = 1'b0;
    bus.almost_full_3 = 1'b0;
    bus.cnt_rd        = 1'b0;
    bus.cnt_idx       = '0;
    repeat (2) step();
    chk("rst_push", 32'(pushes()), 32'd0);
    chk("rst_data", 32'(bus.data_out), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_cnt_valid", 32'(bus.cnt_valid), 32'd0);
    reset = 1'b1;
    step();

    // Streaming to all four destinations
    send(12'h000, 2'd0, 1'b1); chk("stream_stall", 32'(bus.stall), 32'd0);
    send(12'h100, 2'd1, 1'b1); chk("stream_stall", 32'(bus.stall), 32'd0);
    send(12'h200, 2'd2, 1'b1); chk("stream_stall", 32'(bus.stall), 32'd0);
    send(12'h300, 2'd3, 1'b1); chk("stream_stall", 32'(bus.stall), 32'd0);
    repeat (2) step();
    for (int n = 0; n < 4; n++) read_cnt(2'(n), 8'd1);

    // Blocking and order
    bus.almost_full_2 = 1'b1;
    send(12'h2AA, 2'd2, 1'b1);
    chk("blk_stall", 32'(bus.stall), 32'd1);
    chk("blk_nopush", 32'(pushes()), 32'd0);
    send(12'h0BB, 2'd0, 1'b1);
    chk("blk_stall", 32'(bus.stall), 32'd1);
    chk("blk_nopush", 32'(pushes()), 32'd0);
    step();
    chk("blk_nopush", 32'(pushes()), 32'd0);
    bus.almost_full_2 = 1'b0;
    step();
    chk("blk_drain_stall", 32'(bus.stall), 32'd1);
    step();
    chk("blk_after_stall", 32'(bus.stall), 32'd0);

    // Overflow: four held, fifth dropped
    bus.almost_full_1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(12'h1A0 + 12'(i), 2'd1, 1'b1);
      chk("ovf_pre", 32'(bus.overflow), 32'd0);
    end
    send(12'h1A4, 2'd1, 1'b0);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    chk("ovf_stall", 32'(bus.stall), 32'd1);
    repeat (3) step();
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    chk("ovf_nopush", 32'(pushes()), 32'd0);
    bus.almost_full_1 = 1'b0;
    repeat (5) step();
    chk("ovf_drain_stall", 32'(bus.stall), 32'd0);
    chk("ovf_sticky2", 32'(bus.overflow), 32'd1);

    // Simultaneous head issue and tail write
    bus.almost_full_3 = 1'b1;
    send(12'h3C1, 2'd3, 1'b1);
    chk("sim_stall", 32'(bus.stall), 32'd1);
    bus.almost_full_3 = 1'b0;
    send(12'h0CC, 2'd0, 1'b1);
    chk("sim_occ1_stall", 32'(bus.stall), 32'd1);
    step();
    chk("sim_done_stall", 32'(bus.stall), 32'd0);
    step();
    read_cnt(2'd0, 8'd3);
    read_cnt(2'd1, 8'd5);
    read_cnt(2'd2, 8'd2);
    read_cnt(2'd3, 8'd2);

    // Async reset with three words held
    bus.almost_full_2 = 1'b1;
    send(12'h201, 2'd2, 1'b0);
    send(12'h202, 2'd2, 1'b0);
    send(12'h203, 2'd2, 1'b0);
    chk("hold_stall", 32'(bus.stall), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_push", 32'(pushes()), 32'd0);
    chk("arst_data", 32'(bus.data_out), 32'd0);
    chk("arst_stall", 32'(bus.stall), 32'd0);
    chk("arst_ovf", 32'(bus.overflow), 32'd0);
    chk("arst_cnt_out", 32'(bus.cnt_out), 32'd0);
    chk("arst_cnt_valid", 32'(bus.cnt_valid), 32'd0);
    bus.almost_full_2 = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_nopush", 32'(pushes()), 32'd0);
    end
    chk("post_rst_ovf", 32'(bus.overflow), 32'd0);
    chk("post_rst_stall", 32'(bus.stall), 32'd0);
    read_cnt(2'd2, 8'd0);

    // Counter wrap: 256 pushes to destination 0
    for (int i = 0; i < 256; i++) send(12'(i & 255), 2'd0, 1'b1);
    repeat (2) step();
    read_cnt(2'd0, 8'd0);
    step();
    chk("cnt_valid_drop", 32'(bus.cnt_valid), 32'd0);
    chk("cnt_out_hold", 32'(bus.cnt_out), 32'd0);

    repeat (3) step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
